// File: rtl/rrf.sv
// Retirement register file (committed rename map).
//
// Holds the architectural-to-physical map as of the last retired group and
// reports which physical registers were released by each commit lane.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   from_rob_valid    per-lane commit strobe, lane 0 oldest
//   from_rob_rd_phy   per-lane committed destination physical register
//   from_rob_rd_arch  per-lane committed destination architectural register
//   backend_flush     mispredict flush (does not affect this block's state)
//   to_fl_valid       per-lane free-list push, one cycle after the commit
//   to_fl_phy         per-lane freed physical register
//   rrf_map           committed map including this cycle's commits (comb)

module rrf_lane #(
  parameter int ARF_DEPTH = 32,
  parameter int ARF_IDX   = 5,
  parameter int PRF_IDX   = 6
) (
  input  logic [ARF_DEPTH-1:0][PRF_IDX-1:0] map_in,
  input  logic                              valid,
  input  logic [ARF_IDX-1:0]                arch,
  input  logic [PRF_IDX-1:0]                phy,
  output logic [ARF_DEPTH-1:0][PRF_IDX-1:0] map_out,
  output logic                              free_vld,
  output logic [PRF_IDX-1:0]                free_phy
);
  // x0 is hardwired: never remapped, never frees anything.
  always_comb begin
    map_out  = map_in;
    free_vld = valid && (arch != '0);
    free_phy = map_in[arch];
    if (free_vld) map_out[arch] = phy;
  end
endmodule

module rrf #(
  parameter int ID_WIDTH  = 2,
  parameter int ARF_DEPTH = 32,
  parameter int PRF_DEPTH = 64,
  parameter int ARF_IDX   = $clog2(ARF_DEPTH),
  parameter int PRF_IDX   = $clog2(PRF_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ID_WIDTH-1:0]               from_rob_valid,
  input  logic [ID_WIDTH-1:0][PRF_IDX-1:0]  from_rob_rd_phy,
  input  logic [ID_WIDTH-1:0][ARF_IDX-1:0]  from_rob_rd_arch,
  input  logic                              backend_flush,
  output logic [ID_WIDTH-1:0]               to_fl_valid,
  output logic [ID_WIDTH-1:0][PRF_IDX-1:0]  to_fl_phy,
  output logic [ARF_DEPTH-1:0][PRF_IDX-1:0] rrf_map
);
  // Freed registers are dead whether or not the group flushes, and the
  // flushing branch itself retires, so flush has no effect here.
  logic flush_unused;
  assign flush_unused = backend_flush;

  logic [ARF_DEPTH-1:0][PRF_IDX-1:0] map_q;
  logic [ARF_DEPTH-1:0][PRF_IDX-1:0] chain [ID_WIDTH+1];
  logic [ID_WIDTH-1:0]               free_vld;
  logic [ID_WIDTH-1:0][PRF_IDX-1:0]  free_phy;

  assign chain[0] = map_q;

  // Lane k sees the map as left by lanes 0..k-1, which gives same-arch
  // lanes in one group the correct oldest-to-youngest free ordering.
  for (genvar k = 0; k < ID_WIDTH; k++) begin : g_lane
    rrf_lane #(
      .ARF_DEPTH(ARF_DEPTH), .ARF_IDX(ARF_IDX), .PRF_IDX(PRF_IDX)
    ) u_lane (
      .map_in  (chain[k]),
      .valid   (from_rob_valid[k]),
      .arch    (from_rob_rd_arch[k]),
      .phy     (from_rob_rd_phy[k]),
      .map_out (chain[k+1]),
      .free_vld(free_vld[k]),
      .free_phy(free_phy[k])
    );
  end

  assign rrf_map = chain[ID_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARF_DEPTH; i++) map_q[i] <= PRF_IDX'(i);
      to_fl_valid <= '0;
      to_fl_phy   <= '0;
    end else begin
      map_q       <= chain[ID_WIDTH];
      to_fl_valid <= free_vld;
      to_fl_phy   <= free_phy;
    end
  end
endmodule

// File: tb/tb_rrf.sv
module tb_rrf;
  localparam int IW = 2, AD = 32, PD = 64, AI = 5, PI = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [IW-1:0]          from_rob_valid;
  logic [IW-1:0][PI-1:0]  from_rob_rd_phy;
  logic [IW-1:0][AI-1:0]  from_rob_rd_arch;
  logic                   backend_flush;
  logic [IW-1:0]          to_fl_valid;
  logic [IW-1:0][PI-1:0]  to_fl_phy;
  logic [AD-1:0][PI-1:0]  rrf_map;

  rrf #(.ID_WIDTH(IW), .ARF_DEPTH(AD), .PRF_DEPTH(PD)) dut (
    .clk(clk), .rst(rst),
    .from_rob_valid(from_rob_valid), .from_rob_rd_phy(from_rob_rd_phy),
    .from_rob_rd_arch(from_rob_rd_arch), .backend_flush(backend_flush),
    .to_fl_valid(to_fl_valid), .to_fl_phy(to_fl_phy), .rrf_map(rrf_map)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: committed map as a plain array, plus the pushes owed next cycle.
  int            amap [AD];
  logic [IW-1:0] exp_vld;
  int            exp_phy [IW];
  bit            armed = 0;

  task automatic step(input logic [IW-1:0] v, input int a0, input int p0,
                      input int a1, input int p1, input bit r, input bit f);
    int na [AD];
    int fr [IW];
    int a  [IW];
    int p  [IW];
    logic [IW-1:0] fv;
    logic [AD-1:0][PI-1:0] em;
    a[0] = a0; a[1] = a1; p[0] = p0; p[1] = p1;
    @(negedge clk);
    if (armed) begin
      chk("fl_valid", 256'(to_fl_valid), 256'(exp_vld));
      for (int k = 0; k < IW; k++)
        if (exp_vld[k]) chk($sformatf("fl_phy%0d", k), 256'(to_fl_phy[k]), 256'(exp_phy[k]));
    end
    rst = r; backend_flush = f; from_rob_valid = v;
    for (int k = 0; k < IW; k++) begin
      from_rob_rd_arch[k] = AI'(a[k]);
      from_rob_rd_phy[k]  = PI'(p[k]);
    end
    #1;
    na = amap; fv = '0;
    for (int k = 0; k < IW; k++) begin
      fr[k] = 0;
      if (v[k] && a[k] != 0) begin
        fv[k] = 1'b1; fr[k] = na[a[k]]; na[a[k]] = p[k];
      end
    end
    if (!r) begin
      for (int i = 0; i < AD; i++) em[i] = PI'(na[i]);
      chk("rrf_map", 256'(rrf_map), 256'(em));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < AD; i++) amap[i] = i;
      exp_vld = '0;
    end else begin
      amap = na; exp_vld = fv; exp_phy = fr;
    end
    armed = 1;
  endtask

  task automatic do_reset();
    step(2'b00, 0, 0, 0, 0, 1, 0);
    step(2'b00, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 1'b1; backend_flush = 1'b0; from_rob_valid = '0;
    from_rob_rd_phy = '0; from_rob_rd_arch = '0;
    exp_vld = '0;
    for (int i = 0; i < AD; i++) amap[i] = i;
    for (int k = 0; k < IW; k++) exp_phy[k] = 0;

    // Reset state, then single commit arch5 -> phy40.
    do_reset();
    step(2'b00, 0, 0, 0, 0, 0, 0);
    step(2'b01, 5, 40, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    // Same-cycle same-arch pair.
    do_reset();
    step(2'b11, 3, 33, 3, 34, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    // arch0 lane is ignored.
    do_reset();
    step(2'b11, 0, 50, 7, 51, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    // Commit under flush.
    do_reset();
    step(2'b01, 9, 45, 0, 0, 0, 1);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    // Reset wins over a same-cycle commit.
    do_reset();
    step(2'b01, 4, 60, 0, 0, 1, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    // Back-to-back commits to arch2.
    do_reset();
    step(2'b01, 2, 40, 0, 0, 0, 0);
    step(2'b01, 2, 41, 0, 0, 0, 0);
    step(2'b01, 2, 42, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0, 0, 0);

    // Random traffic; narrow arch range half the time to force collisions.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [IW-1:0] rv;
      int ra0, ra1;
      bit narrow;
      rv = IW'($urandom);
      narrow = $urandom_range(0, 1) == 1;
      ra0 = narrow ? $urandom_range(0, 3) : $urandom_range(0, AD-1);
      ra1 = narrow ? $urandom_range(0, 3) : $urandom_range(0, AD-1);
      step(rv, ra0, $urandom_range(0, PD-1), ra1, $urandom_range(0, PD-1),
           $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
    end
    step(2'b00, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
